// File: rtl/cpu_pkg.sv
// Shared constants and types for the boot loader and the RAM-side logic.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        VERIFY,
        DONE
    } ld_state_e;

    typedef logic [DATA_W-1:0] csum_t;

endpackage

// File: rtl/ram_bus_drv.sv
// Tri-state driver for the shared RAM bus; releases the bus whenever oe_i is low.
module ram_bus_drv #(
    parameter int W = 8
) (
    input  logic [W-1:0] data_i,
    input  logic         oe_i,
    inout  wire  [W-1:0] bus_io
);

    assign bus_io = oe_i ? data_i : {W{1'bz}};

endmodule

// File: rtl/ram_loader.sv
// Boot-time loader: streams 16 bytes into the RAM, reads them back and flags a sum mismatch.
module ram_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_in,
    output logic              ram_out,
    output logic [ADDR_W-1:0] ram_add_4,
    inout  wire  [DATA_W-1:0] ram_bus_8,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    ld_state_e         state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] data_q;
    csum_t             checksum_q;
    csum_t             rsum_q;
    csum_t             rsum_d;
    logic              in_ready_q;
    logic              ram_in_q;
    logic              ram_out_q;
    logic [ADDR_W-1:0] ram_add_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    // Running read-back sum including the word currently on the bus.
    assign rsum_d = rsum_q + csum_t'(ram_bus_8);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            rsum_q     <= '0;
            in_ready_q <= 1'b0;
            ram_in_q   <= 1'b0;
            ram_out_q  <= 1'b0;
            ram_add_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        cnt_q      <= '0;
                        checksum_q <= '0;
                        rsum_q     <= '0;
                        ram_add_q  <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready_q) begin
                        data_q     <= in_data;
                        checksum_q <= checksum_q + in_data;
                        in_ready_q <= 1'b0;
                        ram_in_q   <= 1'b1;
                        ram_add_q  <= cnt_q;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    ram_in_q <= 1'b0;
                    if (cnt_q == LAST) begin
                        cnt_q     <= '0;
                        ram_add_q <= '0;
                        ram_out_q <= 1'b1;
                        state_q   <= VERIFY;
                    end else begin
                        cnt_q      <= cnt_q + 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                VERIFY: begin
                    rsum_q    <= rsum_d;
                    cnt_q     <= cnt_q + 1'b1;
                    ram_add_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        ram_out_q <= 1'b0;
                        err_q     <= (rsum_d != checksum_q);
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    ram_bus_drv #(
        .W (DATA_W)
    ) u_bus_drv (
        .data_i (data_q),
        .oe_i   (ram_in_q),
        .bus_io (ram_bus_8)
    );

    assign in_ready  = in_ready_q;
    assign ram_in    = ram_in_q;
    assign ram_out   = ram_out_q;
    assign ram_add_4 = ram_add_q;
    assign busy      = busy_q;
    assign cpu_hold  = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural 16x8 RAM on the shared bus.
module tb_ram_loader;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       start    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       corrupt_en = 1'b0;

    wire        in_ready, ram_in, ram_out, busy, cpu_hold, done, err;
    wire [3:0]  ram_add_4;
    wire [7:0]  ram_bus_8;
    wire [7:0]  checksum;

    logic [7:0] mem [16];
    int cyc = 0;
    int write_cnt = 0;
    int read_cnt = 0;
    int ready_in_write = 0;
    int proto_viol = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ram_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_in    (ram_in),
        .ram_out   (ram_out),
        .ram_add_4 (ram_add_4),
        .ram_bus_8 (ram_bus_8),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    // RAM model: asynchronous read onto the bus, write on the edge ending a write strobe.
    assign ram_bus_8 = ram_out ? mem[ram_add_4] : 8'hzz;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_in) begin
            mem[ram_add_4] <= (corrupt_en && ram_add_4 == 4'd7) ? (ram_bus_8 ^ 8'h01) : ram_bus_8;
            write_cnt <= write_cnt + 1;
        end
        if (ram_out) read_cnt <= read_cnt + 1;
    end

    always @(negedge clk) begin
        if (in_ready && ram_in) ready_in_write <= ready_in_write + 1;
        if ((ram_in && ram_out) || (cpu_hold !== busy)) proto_viol <= proto_viol + 1;
        assert (!(ram_in && ram_out) && cpu_hold === busy)
            else $error("FAIL protocol: ram_in=%b ram_out=%b cpu_hold=%b busy=%b", ram_in, ram_out, cpu_hold, busy);
    end

    task automatic pulse_start(input logic v, input logic [7:0] d);
        @(negedge clk);
        start = 1'b1; in_valid = v; in_data = d;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        in_data = b; in_valid = 1'b1;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (!in_ready) $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_bytes(input logic [7:0] base, input logic [7:0] step, input int first, input int last, input int maxgap);
        for (int k = first; k <= last; k++) begin
            logic [7:0] b;
            b = base + step * 8'(k);
            send_byte(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (!done) $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
        else n_pass++;
    endtask

    task automatic wait_verify();
        int n = 0;
        while (!ram_out && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (!ram_out) $display("FAIL verify_timeout: ram_out=%b after %0d cycles, required 1", ram_out, n);
        else n_pass++;
    endtask

    task automatic check_mem(input string name, input logic [7:0] base, input logic [7:0] step);
        int bad = 0;
        for (int k = 0; k < 16; k++) begin
            logic [7:0] e;
            e = base + step * 8'(k);
            if (mem[k] !== e) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL %s: %0d RAM words wrong, required 0", name, bad);
        else n_pass++;
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if ({in_ready, ram_in, ram_out, busy, cpu_hold, done, err} !== 7'b0 || ram_add_4 !== 4'h0 || checksum !== 8'h00) begin
            $display("FAIL %s: ctrl=%b add=%h sum=%h, required ctrl=0000000 add=0 sum=00",
                     name, {in_ready, ram_in, ram_out, busy, cpu_hold, done, err}, ram_add_4, checksum);
        end else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset_state");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("idle_no_start");
    endtask

    task automatic test_sequential();
        int wb, rb, t0;
        wb = write_cnt; rb = read_cnt;
        pulse_start(1'b1, 8'hAA);
        t0 = cyc;
        n_checks++;
        if ({in_ready, busy, cpu_hold, ram_in} !== 4'b1110)
            $display("FAIL seq_after_start: {rdy,busy,hold,wr}=%b, required 1110", {in_ready, busy, cpu_hold, ram_in});
        else n_pass++;
        load_bytes(8'h00, 8'h01, 0, 15, 0);
        wait_done();
        n_checks++;
        if (cyc - t0 != 48) $display("FAIL seq_latency: start-to-done %0d cycles, required 49", cyc - t0 + 1);
        else n_pass++;
        n_checks++;
        if (write_cnt - wb != 16 || read_cnt - rb != 16)
            $display("FAIL seq_counts: writes=%0d reads=%0d, required 16/16", write_cnt - wb, read_cnt - rb);
        else n_pass++;
        check_mem("seq_ram", 8'h00, 8'h01);
        n_checks++;
        if ({done, err, busy} !== 3'b100 || checksum !== 8'h78)
            $display("FAIL seq_result: done/err/busy=%b sum=%h, required 100 sum=78", {done, err, busy}, checksum);
        else n_pass++;
    endtask

    task automatic test_wrap();
        pulse_start(1'b0, 8'h00);
        load_bytes(8'hFF, 8'h00, 0, 15, 0);
        wait_verify();
        n_checks++;
        if (ram_add_4 !== 4'h0) $display("FAIL wrap_verify_addr: ram_add_4=%h, required 0", ram_add_4);
        else n_pass++;
        wait_done();
        n_checks++;
        if (checksum !== 8'hF0 || err !== 1'b0)
            $display("FAIL wrap_result: sum=%h err=%b, required F0/0", checksum, err);
        else n_pass++;
        check_mem("wrap_ram", 8'hFF, 8'h00);
    endtask

    task automatic test_backpressure();
        int rb;
        rb = ready_in_write;
        pulse_start(1'b0, 8'h00);
        load_bytes(8'h00, 8'h01, 0, 15, 5);
        wait_done();
        check_mem("bp_ram", 8'h00, 8'h01);
        n_checks++;
        if (checksum !== 8'h78 || err !== 1'b0 || ready_in_write != rb)
            $display("FAIL bp_result: sum=%h err=%b ready_in_write=%0d, required 78/0/0", checksum, err, ready_in_write - rb);
        else n_pass++;
    endtask

    task automatic test_corrupt();
        corrupt_en = 1'b1;
        pulse_start(1'b0, 8'h00);
        load_bytes(8'h00, 8'h01, 0, 15, 0);
        wait_done();
        corrupt_en = 1'b0;
        n_checks++;
        if ({done, err} !== 2'b11 || checksum !== 8'h78)
            $display("FAIL corrupt_err: done/err=%b sum=%h, required 11 sum=78", {done, err}, checksum);
        else n_pass++;
        pulse_start(1'b0, 8'h00);
        n_checks++;
        if ({done, err, busy} !== 3'b001)
            $display("FAIL corrupt_restart: done/err/busy=%b, required 001", {done, err, busy});
        else n_pass++;
        load_bytes(8'h00, 8'h01, 0, 15, 0);
        wait_done();
        n_checks++;
        if (err !== 1'b0) $display("FAIL corrupt_clean_reload: err=%b, required 0", err);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int wb, rb;
        wb = write_cnt; rb = read_cnt;
        pulse_start(1'b0, 8'h00);
        load_bytes(8'h10, 8'h03, 0, 4, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_bytes(8'h10, 8'h03, 5, 15, 0);
        wait_verify();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        n_checks++;
        if (checksum !== 8'h68 || err !== 1'b0 || write_cnt - wb != 16 || read_cnt - rb != 16)
            $display("FAIL start_ignored: sum=%h err=%b writes=%0d reads=%0d, required 68/0/16/16",
                     checksum, err, write_cnt - wb, read_cnt - rb);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        pulse_start(1'b0, 8'h00);
        load_bytes(8'h20, 8'h01, 0, 8, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_write");
        rst_n = 1'b0;
        pulse_start(1'b0, 8'h00);
        load_bytes(8'h10, 8'h00, 0, 15, 0);
        wait_verify();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_verify");
        rst_n = 1'b0;
        pulse_start(1'b0, 8'h00);
        load_bytes(8'h01, 8'h01, 0, 15, 0);
        wait_done();
        check_mem("fresh_ram", 8'h01, 8'h01);
        n_checks++;
        if (checksum !== 8'h88 || {done, err} !== 2'b10)
            $display("FAIL fresh_load: sum=%h done/err=%b, required 88/10", checksum, {done, err});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_backpressure();
        test_corrupt();
        test_start_ignored();
        test_reset_mid();
        @(negedge clk);
        n_checks++;
        if (proto_viol != 0 || ready_in_write != 0)
            $display("FAIL protocol_totals: violations=%0d ready_in_write=%0d, required 0/0", proto_viol, ready_in_write);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Boot-time program loader directly upstream of the 16x8 RAM. It owns the RAM control pins (ram_in, ram_out, ram_add_4) and the shared 8-bit RAM bus until a load is finished.
- Accepts a byte stream over a valid/ready interface, fed by a host link such as a UART receiver.
- Writes the bytes to addresses 0..15, reads all 16 back, compares the read-back sum against the write sum, and holds the CPU while active.

Parameters:
- DATA_W, 8, width of the RAM word and the input byte.
- ADDR_W, 4, width of the RAM address.
- DEPTH, 16, number of words loaded. Must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-high (1 = reset), sampled on the clk rising edge.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- in_data  in  8  incoming program byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- ram_in  out  1  RAM write strobe.
- ram_out  out  1  RAM read/bus-drive enable.
- ram_add_4  out  4  RAM address.
- ram_bus_8  inout  8  shared RAM bus; the loader drives it only while ram_in=1, otherwise Z.
- busy  out  1  load or verify in progress.
- cpu_hold  out  1  keeps the CPU halted; equals busy.
- done  out  1  sequence finished; held high until the next start.
- err  out  1  verify mismatch; valid when done=1.
- checksum  out  8  modulo-256 sum of the accepted bytes.

Behaviour:
- All outputs are registered. Reset (rst_n=1) takes effect at the next edge:
  - state goes to IDLE;
  - in_ready, ram_in, ram_out, busy, cpu_hold, done and err go to 0;
  - ram_add_4, the byte counter, checksum and the read-back sum go to 0;
  - the bus driver is released to Z.
- Reset has priority over every other input, including mid-LOAD, mid-WRITE and mid-VERIFY. RAM contents after an aborted load are undefined.
- States and transitions:
  - IDLE: all outputs are 0. On start, go to LOAD with cnt=0, checksum=0 and rsum=0. busy, cpu_hold and in_ready go to 1.
  - LOAD: in_ready=1. On in_valid&&in_ready, capture in_data into data_q, set checksum += in_data (8-bit wrap), set in_ready to 0 and go to WRITE. If in_valid=0, wait indefinitely with no timeout.
  - WRITE (exactly 1 cycle): ram_in=1, ram_add_4=cnt, ram_bus_8=data_q. The RAM captures the word on the edge that ends this cycle. On that edge ram_in goes to 0.
    - If cnt=DEPTH-1: go to VERIFY with cnt=0.
    - Otherwise: cnt+1, go back to LOAD with in_ready=1.
  - VERIFY (DEPTH cycles): ram_out=1, ram_add_4=cnt, bus not driven by the loader. On each edge, rsum += ram_bus_8 and cnt += 1.
    - After the read of address DEPTH-1: ram_out goes to 0, err = (rsum_final != checksum), done=1, busy=0, and the state goes to DONE.
  - DONE: done, err and checksum are held. start re-enters LOAD; done and err clear on that edge.
- Throughput and latency:
  - At most one byte is accepted every 2 cycles.
  - Minimum time from start to done is 1 + 16*2 + 16 cycles.
- start is ignored in LOAD, WRITE and VERIFY.
- ram_in and ram_out are never 1 in the same cycle.
- The loader never drives ram_bus_8 while ram_out=1.
- cnt is ADDR_W bits wide. The wrap from 15 to 0 is the end condition for both the load and the verify pass.
- A simultaneous start and in_valid in IDLE: the byte is not accepted in that cycle.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, ADDR_W and DEPTH constants;
  - loader state enum (IDLE, LOAD, WRITE, VERIFY, DONE);
  - a checksum-width typedef.
- One natural sub-module: ram_bus_drv, the tri-state bus driver (data, oe -> inout). It is reused by any other block that drives ram_bus_8.
- The FSM, counter and both sums stay in ram_loader.

Test Plan:
- Sequential load: send bytes 0x00..0x0F back-to-back against a RAM model.
  - 16 WRITE cycles, with address k carrying data k.
  - 16 VERIFY reads.
  - Ends with done=1, err=0, checksum=0x78.
- Backpressure: same data with in_valid gaps of 0-5 random cycles.
  - Identical RAM contents and checksum.
  - in_ready never high during WRITE.
- Wrap and overflow: send sixteen 0xFF bytes.
  - checksum=0xF0.
  - ram_add_4 returns to 0 at the start of VERIFY.
  - err=0.
- Corruption: the RAM model flips bit 0 of address 7 after it is written.
  - err=1, done=1.
  - A subsequent start clears done and err on the next edge.
- Reset mid-operation: assert rst_n=1 for one cycle after the 9th byte, and again during VERIFY.
  - All outputs 0 and bus Z on the next edge.
  - A new start performs a complete fresh load with checksum restarted from 0.
- Protocol checks:
  - start pulsed during LOAD and during VERIFY has no effect.
  - Assertions: ram_in&&ram_out never true; bus driven only when ram_in=1; cpu_hold==busy on every cycle.
